fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DataWidth, default 32, payload width per requester.
REQ-002 Parameter NumReq, default 4, number of requesters (power of two, >=2).
REQ-003 Parameter MaxBurst, default 4, max beats per grant (>=1).
REQ-004 Derived IdWidth = $clog2(NumReq); CntWidth = $clog2(MaxBurst+1).
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 reqValid  input  NumReq  per-requester beat valid.
REQ-008 reqData  input  NumReq*DataWidth  payloads; requester i at bits [i*DataWidth +: DataWidth].
REQ-009 reqLast  input  NumReq  per-requester last beat of packet.
REQ-010 reqReady  output  NumReq  per-requester beat accepted this cycle when valid.
REQ-011 full  input  1  FIFO full flag.
REQ-012 writeEn  output  1  FIFO write strobe.
REQ-013 writeData  output  IdWidth+DataWidth  {owner id, payload} to FIFO.
REQ-014 grantValid  output  1  a requester currently owns the FIFO write port.
REQ-015 grantId  output  IdWidth  current owner index.

Function
REQ-016 FSM states IDLE and BURST; SHALL be in IDLE after reset.
REQ-017 IDLE: if any reqValid, SHALL select the first valid requester scanning rrPtr, rrPtr+1, ... modulo NumReq, register it as owner, clear beatCnt, enter BURST next cycle.
REQ-018 IDLE: reqReady SHALL be all zero, writeEn 0, grantValid 0 (one-cycle arbitration latency).
REQ-019 BURST: grantValid=1, grantId=owner; reqReady[owner] = !full; all other reqReady bits 0.
REQ-020 BURST: writeEn = reqValid[owner] && !full, combinational; writeData = {owner, reqData[owner]}.
REQ-021 writeEn SHALL never be 1 while full is 1.
REQ-022 Each cycle with writeEn=1 SHALL increment beatCnt by 1.
REQ-023 Burst ends on a beat with writeEn=1 and (reqLast[owner]=1 or beatCnt+1 == MaxBurst); FSM SHALL return to IDLE next cycle.
REQ-024 On burst end rrPtr SHALL become (owner+1) mod NumReq; rrPtr otherwise unchanged.
REQ-025 Owner deasserting reqValid or full=1 in BURST SHALL stall (hold owner, beatCnt) with no timeout.
REQ-026 reqLast without reqValid or while stalled SHALL be ignored.
REQ-027 Non-owner valid inputs SHALL have no effect during BURST; their data SHALL not reach writeData.
REQ-028 With MaxBurst=1 every grant SHALL transfer exactly one beat.
REQ-029 A requester holding reqValid continuously SHALL be granted within NumReq-1 intervening grants (starvation freedom).

Reset
REQ-030 While rst=1 at a rising edge: state=IDLE, rrPtr=0, owner=0, beatCnt=0.
REQ-031 Outputs during/after reset: reqReady=0, writeEn=0, grantValid=0, grantId=0; writeData don't-care but writeEn low.
REQ-032 rst asserted mid-burst SHALL abort the burst with no write in that cycle; the next grant after reset starts scan from requester 0.

Verification
REQ-033 Reset then reqValid=4'b1111, reqLast=4'b1111, full=0 -> grants in order 0,1,2,3,0, each one writeEn beat, 1 idle cycle between.
REQ-034 Requester 2 alone, 6 beats, reqLast on beat 6, MaxBurst=4 -> beats 1-4 written as one grant, IDLE one cycle, beats 5-6 second grant; writeData[top IdWidth bits]=2.
REQ-035 Owner 1 in BURST, full=1 for 3 cycles with reqValid[1]=1 -> writeEn=0, reqReady[1]=0, grantId=1 held; write resumes cycle full drops.
REQ-036 Owner 0 deasserts reqValid for 2 cycles mid-burst while requester 3 valid -> owner stays 0, no writes, burst completes afterwards, then 3 granted.
REQ-037 rst pulse during beat 2 of owner 3's burst -> writeEn=0 that cycle, grantValid=0 next cycle, next grant to lowest valid index.
REQ-038 Formal: writeEn -> !full; $onehot0(reqReady); reqReady!=0 -> grantValid; writeEn -> reqValid[grantId].

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time ownership of a FIFO write port
// for a burst of up to MaxBurst beats, tagging each written word with the owner index.
module fifo_wr_arbiter #(
  parameter  int DataWidth = 32,
  parameter  int NumReq    = 4,
  parameter  int MaxBurst  = 4,
  localparam int IdWidth   = $clog2(NumReq),
  localparam int CntWidth  = $clog2(MaxBurst + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumReq-1:0]             reqValid,
  input  logic [NumReq*DataWidth-1:0]   reqData,
  input  logic [NumReq-1:0]             reqLast,
  output logic [NumReq-1:0]             reqReady,
  input  logic                          full,
  output logic                          writeEn,
  output logic [IdWidth+DataWidth-1:0]  writeData,
  output logic                          grantValid,
  output logic [IdWidth-1:0]            grantId,
  output logic                          dbg_state
);

  // Handshake: a beat from requester i transfers in any cycle where reqValid[i] and
  // reqReady[i] are both high; reqReady is only offered to the current owner, and only
  // while the FIFO is not full, so writeEn is exactly that transfer condition.

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IdWidth-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdWidth-1:0]    owner_q, owner_d;
  logic [CntWidth-1:0]   beat_cnt_q, beat_cnt_d;

  logic [IdWidth-1:0]    pick_id;
  logic                  pick_valid;
  logic [IdWidth-1:0]    scan_idx;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DataWidth-1:0]  owner_data;
  logic                  in_burst;
  logic                  write_en;
  logic                  last_beat;

  // Rotating scan starting at rr_ptr; NumReq is a power of two so the index wraps for free.
  always_comb begin
    pick_id    = '0;
    pick_valid = 1'b0;
    scan_idx   = '0;
    for (int i = 0; i < NumReq; i++) begin
      scan_idx = rr_ptr_q + IdWidth'(i);
      if (!pick_valid && reqValid[scan_idx]) begin
        pick_id    = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (owner_q == IdWidth'(i)) begin
        owner_valid = reqValid[i];
        owner_last  = reqLast[i];
        owner_data  = reqData[i*DataWidth +: DataWidth];
      end
    end
  end

  // Reset masks the write path combinationally so an aborted burst never writes.
  assign in_burst  = (state_q == BURST) && !rst;
  assign write_en  = in_burst && owner_valid && !full;
  assign last_beat = owner_last || (beat_cnt_q == CntWidth'(MaxBurst - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d    = pick_id;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (write_en) begin
          beat_cnt_d = beat_cnt_q + CntWidth'(1);
          if (last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = owner_q + IdWidth'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reqReady   = '0;
    grantValid = in_burst;
    grantId    = in_burst ? owner_q : '0;
    if (in_burst) begin
      reqReady[owner_q] = !full;
    end
    writeEn    = write_en;
    writeData  = {owner_q, owner_data};
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: predicted FIFO words go into a queue as stimulus is
// driven and are popped and compared whenever the arbiter strobes writeEn.
module tb_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;
  localparam int W  = IW + DW;

  logic              clk;
  logic              rst;
  logic              full;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_data;
  logic              write_en;
  logic [W-1:0]      write_data;
  logic              grant_valid;
  logic [IW-1:0]     grant_id;
  logic              dbg_state;

  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      mon_exp;
  logic [DW-1:0]     d [NR];
  logic [DW-1:0]     v;
  int                tests_run = 0;
  int                tests_failed = 0;
  bit                mon_en = 1'b0;

  fifo_wr_arbiter #(
    .DataWidth (DW),
    .NumReq    (NR),
    .MaxBurst  (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reqValid   (req_valid),
    .reqData    (req_data),
    .reqLast    (req_last),
    .reqReady   (req_ready),
    .full       (full),
    .writeEn    (write_en),
    .writeData  (write_data),
    .grantValid (grant_valid),
    .grantId    (grant_id),
    .dbg_state  (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int r, input logic [DW-1:0] val);
    req_data[r*DW +: DW] = val;
  endtask

  // Per-cycle invariants plus scoreboard pop on every FIFO write.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_we_full", 64'(write_en && full), 64'd0);
      chk("inv_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      chk("inv_ready_grant", 64'((req_ready != '0) && !grant_valid), 64'd0);
      chk("inv_we_valid", 64'(write_en && !req_valid[grant_id]), 64'd0);
      if (write_en) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("sb_write_data", 64'(write_data), 64'(mon_exp));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    full      = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) d[i] = $urandom;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(write_en), 64'd0);
    chk("rst_gv", 64'(grant_valid), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gv", 64'(grant_valid), 64'd0);
    chk("post_rst_state", 64'(dbg_state), 64'd0);
    adv();

    // All requesters valid with single-beat packets: round robin 0,1,2,3,0
    req_valid = '1;
    req_last  = '1;
    for (int i = 0; i < NR; i++) set_data(i, d[i]);
    for (int k = 0; k < 5; k++) exp_q.push_back({IW'(k % NR), d[k % NR]});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("a_idle_gv", 64'(grant_valid), 64'd0);
      chk("a_idle_ready", 64'(req_ready), 64'd0);
      chk("a_idle_we", 64'(write_en), 64'd0);
      adv();
      @(negedge clk);
      chk("a_gv", 64'(grant_valid), 64'd1);
      chk("a_gid", 64'(grant_id), 64'(k % NR));
      chk("a_we", 64'(write_en), 64'd1);
      adv();
    end
    req_valid = '0;
    req_last  = '0;
    chk("a_drain", 64'(exp_q.size()), 64'd0);

    // Requester 2 alone, 6-beat packet split by MaxBurst into 4 + 2
    req_valid = 4'b0100;
    @(negedge clk);
    chk("b_idle_gv", 64'(grant_valid), 64'd0);
    adv();
    for (int b = 1; b <= 6; b++) begin
      if (b == 5) begin
        @(negedge clk);
        chk("b_gap_gv", 64'(grant_valid), 64'd0);
        chk("b_gap_we", 64'(write_en), 64'd0);
        adv();
      end
      v = $urandom;
      set_data(2, v);
      req_last[2] = (b == 6);
      exp_q.push_back({2'd2, v});
      @(negedge clk);
      chk("b_gv", 64'(grant_valid), 64'd1);
      chk("b_gid", 64'(grant_id), 64'd2);
      chk("b_we", 64'(write_en), 64'd1);
      chk("b_wd_id", 64'(write_data[W-1 -: IW]), 64'd2);
      adv();
    end
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("b_end_gv", 64'(grant_valid), 64'd0);
    chk("b_drain", 64'(exp_q.size()), 64'd0);
    adv();

    // Owner 1 stalled by full for 3 cycles; reqLast during the stall is ignored
    req_valid = 4'b0010;
    @(negedge clk);
    chk("c_idle_gv", 64'(grant_valid), 64'd0);
    adv();
    v = $urandom;
    set_data(1, v);
    exp_q.push_back({2'd1, v});
    @(negedge clk);
    chk("c_gid", 64'(grant_id), 64'd1);
    chk("c_we", 64'(write_en), 64'd1);
    adv();
    full = 1'b1;
    req_last[1] = 1'b1;
    set_data(1, $urandom);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("c_stall_we", 64'(write_en), 64'd0);
      chk("c_stall_ready", 64'(req_ready), 64'd0);
      chk("c_stall_gv", 64'(grant_valid), 64'd1);
      chk("c_stall_gid", 64'(grant_id), 64'd1);
      adv();
    end
    full = 1'b0;
    v = $urandom;
    set_data(1, v);
    exp_q.push_back({2'd1, v});
    @(negedge clk);
    chk("c_resume_we", 64'(write_en), 64'd1);
    chk("c_resume_ready", 64'(req_ready), 64'b0010);
    adv();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("c_end_gv", 64'(grant_valid), 64'd0);
    chk("c_drain", 64'(exp_q.size()), 64'd0);
    adv();

    // Owner 0 drops valid for 2 cycles while requester 3 waits
    req_valid = 4'b0001;
    @(negedge clk);
    chk("d_idle_gv", 64'(grant_valid), 64'd0);
    adv();
    req_valid = 4'b1001;
    set_data(3, $urandom);
    v = $urandom;
    set_data(0, v);
    exp_q.push_back({2'd0, v});
    @(negedge clk);
    chk("d_gid", 64'(grant_id), 64'd0);
    chk("d_we", 64'(write_en), 64'd1);
    adv();
    req_valid = 4'b1000;
    req_last  = 4'b0001;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("d_hold_we", 64'(write_en), 64'd0);
      chk("d_hold_gv", 64'(grant_valid), 64'd1);
      chk("d_hold_gid", 64'(grant_id), 64'd0);
      chk("d_hold_ready", 64'(req_ready), 64'b0001);
      adv();
    end
    req_valid = 4'b1001;
    v = $urandom;
    set_data(0, v);
    exp_q.push_back({2'd0, v});
    @(negedge clk);
    chk("d_last_gid", 64'(grant_id), 64'd0);
    chk("d_last_we", 64'(write_en), 64'd1);
    adv();
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    v = $urandom;
    set_data(3, v);
    exp_q.push_back({2'd3, v});
    @(negedge clk);
    chk("d_gap_gv", 64'(grant_valid), 64'd0);
    adv();
    @(negedge clk);
    chk("d_g3_gid", 64'(grant_id), 64'd3);
    chk("d_g3_we", 64'(write_en), 64'd1);
    adv();
    req_valid = '0;
    req_last  = '0;
    chk("d_drain", 64'(exp_q.size()), 64'd0);

    // Single beat to requester 1 moves the round-robin pointer to 2
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    v = $urandom;
    set_data(1, v);
    exp_q.push_back({2'd1, v});
    @(negedge clk);
    chk("e_pre_idle_gv", 64'(grant_valid), 64'd0);
    adv();
    @(negedge clk);
    chk("e_pre_gid", 64'(grant_id), 64'd1);
    adv();

    // Reset during beat 2 of owner 3's burst
    req_valid = 4'b1000;
    req_last  = '0;
    @(negedge clk);
    chk("e_idle_gv", 64'(grant_valid), 64'd0);
    adv();
    v = $urandom;
    set_data(3, v);
    exp_q.push_back({2'd3, v});
    @(negedge clk);
    chk("e_b1_gid", 64'(grant_id), 64'd3);
    chk("e_b1_we", 64'(write_en), 64'd1);
    adv();
    rst = 1'b1;
    set_data(3, $urandom);
    @(negedge clk);
    chk("e_rst_we", 64'(write_en), 64'd0);
    chk("e_rst_ready", 64'(req_ready), 64'd0);
    chk("e_rst_gv", 64'(grant_valid), 64'd0);
    adv();
    rst       = 1'b0;
    req_valid = 4'b1010;
    req_last  = 4'b1010;
    v = $urandom;
    set_data(1, v);
    exp_q.push_back({2'd1, v});
    @(negedge clk);
    chk("e_post_gv", 64'(grant_valid), 64'd0);
    chk("e_post_state", 64'(dbg_state), 64'd0);
    adv();
    @(negedge clk);
    chk("e_regrant_gid", 64'(grant_id), 64'd1);
    chk("e_regrant_we", 64'(write_en), 64'd1);
    adv();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("final_drain", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
